// File: rtl/bioee_capture_16in_32out_if.sv
// Capture/readout bundle for bioee_capture_16in_32out.
//   master: host/front-end side; drives capture control, the sample bus and the read strobe.
//   slave : capture block side; returns packed read data, FIFO level and status flags.
//   capture_start/stop   one-cycle control pulses
//   capture_length       sample count for a finite capture (0 = unlimited)
//   sample_en/vectorinput 16-bit sample strobe and data
//   pipeO_capture_read   pop strobe; pipeO_capture_data is the registered head word
//   pipeO_capture_ready  level >= one pipe block
//   capture_busy/overflow/underflow/level  status
interface bioee_capture_16in_32out_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              capture_start;
    logic              capture_stop;
    logic [31:0]       capture_length;
    logic              sample_en;
    logic [15:0]       vectorinput;
    logic              pipeO_capture_read;
    logic [31:0]       pipeO_capture_data;
    logic              pipeO_capture_ready;
    logic              capture_busy;
    logic              capture_overflow;
    logic              capture_underflow;
    logic [ADDR_W:0]   capture_level;

    modport master (
        output capture_start, capture_stop, capture_length, sample_en, vectorinput,
               pipeO_capture_read,
        input  pipeO_capture_data, pipeO_capture_ready, capture_busy, capture_overflow,
               capture_underflow, capture_level
    );

    modport slave (
        input  capture_start, capture_stop, capture_length, sample_en, vectorinput,
               pipeO_capture_read,
        output pipeO_capture_data, pipeO_capture_ready, capture_busy, capture_overflow,
               capture_underflow, capture_level
    );
endinterface

// File: rtl/bioee_capture_16in_32out.sv
// Samples a 16-bit BioEE vector bus, packs sample pairs MSB-first into 32-bit words and buffers
// them in a 2^ADDR_W-word FIFO drained by the host pipe-out.
//   captureclk    capture and readout clock (rising edge)
//   capturereset  synchronous active-high reset; discards buffered data
//   cap           slave side of bioee_capture_16in_32out_if (control, samples, readout, status)
module bioee_capture_16in_32out #(
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input logic                       captureclk,
    input logic                       capturereset,
    bioee_capture_16in_32out_if.slave cap
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   LevelOne = 1;
    localparam logic [ADDR_W-1:0] PtrOne   = 1;

    typedef enum logic [1:0] {StIdle, StCapture, StFlush} state_e;

    state_e            state_q, state_d;
    logic [31:0]       length_q, length_d;
    logic [31:0]       count_q, count_d;
    logic              half_q, half_d;
    logic [15:0]       held_q, held_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;
    logic [31:0]       data_q;
    logic              ready_q, ready_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              clear_flags;
    logic              wr_req, wr_ok, rd_ok;
    logic [31:0]       wr_word;
    logic [31:0]       mem [Depth];

    // Capture FSM and pair packing.
    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        count_d     = count_q;
        half_d      = half_q;
        held_d      = held_q;
        wr_req      = 1'b0;
        wr_word     = '0;
        clear_flags = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cap.capture_start) begin
                    state_d     = StCapture;
                    length_d    = cap.capture_length;
                    count_d     = '0;
                    half_d      = 1'b0;
                    clear_flags = 1'b1;
                end
            end
            StCapture: begin
                if (cap.sample_en) begin
                    count_d = count_q + 32'd1;
                    if (half_q) begin
                        wr_req  = 1'b1;
                        wr_word = {held_q, cap.vectorinput};
                        half_d  = 1'b0;
                    end else begin
                        held_d = cap.vectorinput;
                        half_d = 1'b1;
                    end
                end
                // Exit is judged after this cycle's sample has been taken.
                if (cap.capture_stop ||
                    (length_q != '0 && cap.sample_en && count_d == length_q)) begin
                    state_d = half_d ? StFlush : StIdle;
                end
            end
            StFlush: begin
                wr_req  = 1'b1;
                wr_word = {held_q, 16'h0000};
                half_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO bookkeeping; a full FIFO still accepts a write when a read frees a slot this cycle.
    always_comb begin
        rd_ok       = cap.pipeO_capture_read && (level_q != '0);
        wr_ok       = wr_req && (!level_q[ADDR_W] || rd_ok);
        level_d     = level_q;
        if (wr_ok && !rd_ok) begin
            level_d = level_q + LevelOne;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - LevelOne;
        end
        ready_d     = 32'(level_d) >= BLOCK_WORDS;
        overflow_d  = (clear_flags ? 1'b0 : overflow_q) | (wr_req && !wr_ok);
        underflow_d = (clear_flags ? 1'b0 : underflow_q) |
                      (cap.pipeO_capture_read && level_q == '0);
    end

    always_ff @(posedge captureclk) begin
        if (capturereset) begin
            state_q     <= StIdle;
            length_q    <= '0;
            count_q     <= '0;
            half_q      <= 1'b0;
            held_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            count_q     <= count_d;
            half_q      <= half_d;
            held_q      <= held_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
                data_q   <= mem[rd_ptr_q];
            end
        end
    end

    // Storage has no reset; contents are only meaningful below the level count.
    always_ff @(posedge captureclk) begin
        if (!capturereset && wr_ok) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    assign cap.pipeO_capture_data  = data_q;
    assign cap.pipeO_capture_ready = ready_q;
    assign cap.capture_busy        = (state_q != StIdle);
    assign cap.capture_overflow    = overflow_q;
    assign cap.capture_underflow   = underflow_q;
    assign cap.capture_level       = level_q;
endmodule

// File: doc/bioee_capture_16in_32out.md
Name: bioee_capture_16in_32out

Overview:
Input-side counterpart of the 32-in/16-out vector output path. It samples a 16-bit vector bus from the BioEE front end and packs each pair of samples into a 32-bit word. Packed words are buffered in an internal FIFO that the host drains over a pipe-out. A small state machine handles start/stop and finite-length captures. Everything runs in a single clock domain.

Parameters:
ADDR_W, 14, FIFO address width; depth = 2^ADDR_W 32-bit words.
BLOCK_WORDS, 256, FIFO level at which pipeO_capture_ready asserts; this is one host pipe block.

Ports:
captureclk  input  1  capture and readout clock; all logic is on its rising edge.
capturereset  input  1  synchronous, active-high reset.
capture_start  input  1  one-cycle pulse that begins a capture.
capture_stop  input  1  one-cycle pulse that ends a capture.
capture_length  input  32  number of 16-bit samples to take; 0 means unlimited. Latched when capture starts.
sample_en  input  1  sample strobe; vectorinput is taken on cycles where this is high.
vectorinput  input  16  vector bus being sampled.
pipeO_capture_read  input  1  host read strobe; pops one word.
pipeO_capture_data  output  32  registered read data.
pipeO_capture_ready  output  1  high when level >= BLOCK_WORDS.
capture_busy  output  1  high in the CAPTURE and FLUSH states.
capture_overflow  output  1  sticky: a packed word was dropped.
capture_underflow  output  1  sticky: a read was attempted while empty.
capture_level  output  ADDR_W+1  current FIFO word count.

Behaviour:
- Reset (synchronous, capturereset=1):
  - state=IDLE; write/read pointers=0; level=0.
  - All outputs 0, including pipeO_capture_data=32'h0.
  - Sample counter and half-word flag cleared.
  - FIFO contents are don't-care.
  - Reset mid-capture discards all buffered data.
- State IDLE:
  - capture_start -> CAPTURE.
  - On that transition: latch capture_length, clear sample counter, half flag, capture_overflow and capture_underflow.
  - FIFO contents are kept, so the host can finish draining an earlier capture.
  - capture_stop is ignored in IDLE; if start and stop arrive together, start wins.
- State CAPTURE:
  - Each sample_en cycle takes vectorinput.
  - First sample of a pair goes into holding register bits [31:16] and sets the half flag.
  - Second sample forms word {first, second}, is written to the FIFO on that same edge, and clears the half flag.
  - Sample counter increments per sample and wraps at 2^32.
  - Exit condition: capture_stop, OR (capture_length!=0 AND this sample is sample number capture_length).
    - If the half flag is set after the exit-cycle sample is taken -> FLUSH.
    - Otherwise -> IDLE.
  - capture_stop coinciding with sample_en: the sample is taken first, then the exit is evaluated.
  - capture_start is ignored while in CAPTURE.
- State FLUSH (one cycle):
  - Writes {held, 16'h0000}, clears the half flag, then -> IDLE.
  - sample_en is ignored here.
- FIFO write:
  - Accepted if level < 2^ADDR_W, or if a read is accepted in the same cycle.
  - Otherwise the word is dropped, capture_overflow is set, and capture continues.
- FIFO read:
  - pipeO_capture_read with level > 0 pops the head.
  - pipeO_capture_data updates on the next edge (1-cycle latency) and holds between reads.
  - Read while empty: pointer unchanged, data unchanged, capture_underflow set.
- Simultaneous write and read: level is unchanged and both pointers advance.
- Level arithmetic and flags:
  - capture_level = net change from accepted writes and reads, range 0..2^ADDR_W.
  - Pointers wrap modulo 2^ADDR_W.
  - pipeO_capture_ready and capture_level are registered and reflect the current cycle's update after the edge.
- Word ordering: first sample sits in the MSB half, mirroring the output path's MSB-first 32-to-16 unpacking.

Test Plan:
1. Reset, start with capture_length=4, drive sample_en on 4 consecutive cycles with 16'h1111, 2222, 3333, 4444 -> 2 words 32'h11112222 and 32'h33334444; level=2; busy falls the cycle after the 4th sample.
2. capture_length=3 with samples A, B, C -> words 32'hAAAABBBB and 32'hCCCC0000; FLUSH lasts exactly one cycle.
3. capture_length=0, write 2^ADDR_W+1 words with no reads -> level=2^ADDR_W; overflow=1; the dropped word is the last one; the first 2^ADDR_W words read back intact.
4. FIFO full with read and completed pair in the same cycle -> no overflow; level stays full; the read returns the oldest word one cycle later.
5. Read with level=0 -> underflow=1, data unchanged; a following start clears the sticky flag.
6. Write BLOCK_WORDS-1 words (ready=0), then one more (ready=1), then read one (ready=0); assert capturereset mid-capture -> level=0, busy=0, all flags 0.
